coupler_16_to_32: RTL

Width-doubling stage directly upstream of the 32-tuple merger. It drains a 16-tuple sorted stream from a show-ahead FIFO and packs consecutive pairs of 16-tuple words into 32-tuple words. Output is a show-ahead FIFO interface that plugs straight into a merger input (data, empty, read). All-zero run terminators are preserved. A run whose length is an odd number of 16-tuple words is padded to a full 32-tuple word.

---
 rtl/bonsai_pkg.sv | 32 +++
 rtl/coupler_16_to_32_if.sv | 27 ++
 rtl/wide_fifo2.sv | 55 +++++
 rtl/coupler_16_to_32.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/bonsai_pkg.sv
// Shared definitions for the bonsai merge-tree couplers: packing FSM state
// encoding, PAD tuple construction and terminator detection.
package bonsai_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    HIGH = 2'd1,
    TERM = 2'd2
  } state_t;

  // Widest tuple the helpers below support; callers cast results down to
  // their own tuple width.
  localparam int MAX_TUPLE_WIDTH  = 512;
  localparam int MAX_WORD16_WIDTH = 16 * MAX_TUPLE_WIDTH;

  // PAD tuple: key field all ones, payload zero, so it sorts after any real key
  function automatic logic [MAX_TUPLE_WIDTH-1:0] pad_tuple(input int key_width);
    logic [MAX_TUPLE_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_TUPLE_WIDTH; i++) begin
      p[i] = (i < key_width);
    end
    return p;
  endfunction

  // A 16-tuple word is a run terminator when every bit is zero; narrower
  // words are passed zero-extended, which leaves the result unchanged.
  function automatic logic is_terminator(input logic [MAX_WORD16_WIDTH-1:0] word);
    return (word == '0);
  endfunction

endpackage

// File: rtl/coupler_16_to_32_if.sv
// Bus bundle for the 16-to-32 coupler: upstream show-ahead FIFO head, the
// downstream show-ahead output and the statistics outputs.
// slave  = the coupler itself, master = the environment driving it.
interface coupler_16_to_32_if #(
  parameter int DATA_WIDTH = 128
);

  logic [16*DATA_WIDTH-1:0] i_fifo;
  logic                     i_fifo_empty;
  logic                     o_fifo_read;
  logic [32*DATA_WIDTH-1:0] o_data;
  logic                     o_empty;
  logic                     i_read;
  logic [31:0]              o_run_count;
  logic [31:0]              o_pad_count;

  modport slave (
    input  i_fifo, i_fifo_empty, i_read,
    output o_fifo_read, o_data, o_empty, o_run_count, o_pad_count
  );

  modport master (
    output i_fifo, i_fifo_empty, i_read,
    input  o_fifo_read, o_data, o_empty, o_run_count, o_pad_count
  );

endinterface

// File: rtl/wide_fifo2.sv
// Two-entry show-ahead buffer. data always shows the oldest entry; a pop
// while empty and a push while full are both ignored.
module wide_fifo2 #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & (count != 2'd2);
  assign do_pop  = pop & (count != 2'd0);
  assign data    = mem[rd_ptr];
  assign empty   = (count == 2'd0);

  // Storage is not reset; the occupancy count decides what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coupler_16_to_32.sv
// Width-doubling coupler: packs pairs of 16-tuple words from an upstream
// show-ahead FIFO into 32-tuple words for a merger input. Zero terminators
// pass through as zero wide words; an odd-length run gets its last wide
// word filled with PAD tuples before the terminator.
// Build option: define COUPLER_STATS_EN to make o_run_count/o_pad_count
// live counters; otherwise they are tied to zero.
module coupler_16_to_32
  import bonsai_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80
) (
  input logic               i_clk,
  input logic               i_rst,
  coupler_16_to_32_if.slave bus
);

  localparam int NARROW_W = 16 * DATA_WIDTH;
  localparam int WIDE_W   = 32 * DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] PAD_TUPLE = DATA_WIDTH'(pad_tuple(KEY_WIDTH));
  localparam logic [NARROW_W-1:0]   PAD_HALF  = {16{PAD_TUPLE}};

  state_t              state;
  logic [NARROW_W-1:0] lower;
  logic                pop_up;
  logic                in_term;
  logic                push;
  logic                push_zero;
  logic                push_pad;
  logic [WIDE_W-1:0]   push_data;
  logic [WIDE_W-1:0]   buf_data;
  logic                buf_empty;
  logic                buf_pop;
  logic [1:0]          count;
  logic                out_empty;

  assign in_term = is_terminator(MAX_WORD16_WIDTH'(bus.i_fifo));

  // Upstream reads depend only on registered state, never on i_read.
  assign pop_up = ~i_rst & ~bus.i_fifo_empty & (state != TERM) & (count < 2'd2);
  assign bus.o_fifo_read = pop_up;

  assign out_empty   = i_rst | buf_empty;
  assign buf_pop     = bus.i_read & ~out_empty;
  assign bus.o_empty = out_empty;
  assign bus.o_data  = buf_data;

  // Decide what, if anything, enters the output buffer this cycle.
  always_comb begin
    push      = 1'b0;
    push_zero = 1'b0;
    push_pad  = 1'b0;
    case (state)
      LOW: begin
        if (pop_up && in_term) begin
          push      = 1'b1;
          push_zero = 1'b1;
        end
      end
      HIGH: begin
        if (pop_up) begin
          push     = 1'b1;
          push_pad = in_term;
        end
      end
      TERM: begin
        if (count < 2'd2) begin
          push      = 1'b1;
          push_zero = 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (push_zero) begin
      push_data = '0;
    end else if (push_pad) begin
      push_data = {PAD_HALF, lower};
    end else begin
      push_data = {bus.i_fifo, lower};
    end
  end

  // Packing FSM: hold the lower half, then pair it or pad it out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= LOW;
      lower <= '0;
    end else begin
      case (state)
        LOW: begin
          if (pop_up && !in_term) begin
            lower <= bus.i_fifo;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (pop_up) begin
            state <= in_term ? TERM : LOW;
          end
        end
        TERM: begin
          if (count < 2'd2) begin
            state <= LOW;
          end
        end
        default: state <= LOW;
      endcase
    end
  end

  wide_fifo2 #(
    .WIDTH (WIDE_W)
  ) u_out_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (buf_pop),
    .data      (buf_data),
    .empty     (buf_empty),
    .count     (count)
  );

`ifdef COUPLER_STATS_EN
  logic [31:0] run_count;
  logic [31:0] pad_count;

  // Count terminators and padded words as they enter the output buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_count <= '0;
      pad_count <= '0;
    end else begin
      if (push_zero) begin
        run_count <= run_count + 32'd1;
      end
      if (push_pad) begin
        pad_count <= pad_count + 32'd1;
      end
    end
  end

  assign bus.o_run_count = run_count;
  assign bus.o_pad_count = pad_count;
`else
  assign bus.o_run_count = '0;
  assign bus.o_pad_count = '0;
`endif

endmodule
